fifo_sample_reader: RTL and testbench
=====================================

// Module: fifo_sample_reader
// PURPOSE
// - Consumer (read side) of the sample FIFO that funct_generator fills through wr_en_o/data_o.
// - Pops one signed sample whenever the FIFO is non-empty and the block is enabled.
// - Serialises each sample MSB-first on an SPI-style DAC link (cs_n/sclk/sdo).
// - Sits between the FIFO read port and the off-chip DAC pins; one sample per frame.
// PARAMETERS
// - DATA_WIDTH  16  sample width; taken from fifo_defines_pkg, must match the FIFO data width.
// - CLK_DIV     2   clk cycles per sclk half-period; legal range 1..255.
// PORTS
// - clk           in   1           system clock; all logic on posedge.
// - rst           in   1           asynchronous reset, active-high.
// - en_i          in   1           enables new FIFO reads; a frame already started always completes.
// - empty_i       in   1           FIFO empty flag.
// - data_i        in   DATA_WIDTH  FIFO read data, signed; valid the cycle after rd_en_o (registered FIFO).
// - rd_en_o       out  1           FIFO read strobe, one-cycle pulse.
// - cs_n_o        out  1           DAC chip select, active-low.
// - sclk_o        out  1           DAC serial clock, idle low.
// - sdo_o         out  1           serial data; changes on sclk falling edge, DAC samples on rising edge.
// - busy_o        out  1           high in every state except IDLE.
// - frame_done_o  out  1           one-cycle pulse on the last GAP cycle of each frame.
// BEHAVIOUR
// - Reset values: rd_en_o=0, cs_n_o=1, sclk_o=0, sdo_o=0, busy_o=0, frame_done_o=0.
// - Reset also clears the internal shift register and all counters; FSM returns to IDLE.
// - All outputs are registered (no combinational paths from inputs).
// - FSM states: IDLE, READ, LATCH, SHIFT, GAP.
// - IDLE: if en_i && !empty_i, go to READ; otherwise stay.
// - READ (1 cycle): rd_en_o=1, then go to LATCH. rd_en_o is never asserted while empty_i=1.
// - LATCH (1 cycle): shreg <= data_i; bit_cnt <= DATA_WIDTH-1; cs_n_o <= 0; sdo_o <= data_i[MSB]; go to SHIFT.
// - SHIFT: a divider counter runs 0..CLK_DIV-1.
//   - sclk_o is low for CLK_DIV cycles, then high for CLK_DIV cycles.
//   - At the end of each high phase, sclk_o falls and shreg shifts left.
//   - On that same fall, sdo_o takes the next bit and bit_cnt decrements.
//   - After the DATA_WIDTH-th high phase ends: sclk_o=0, cs_n_o=1, go to GAP.
//   - SHIFT occupies exactly 2*CLK_DIV*DATA_WIDTH cycles.
// - GAP: cs_n_o held high for CLK_DIV cycles.
//   - frame_done_o pulses on the last GAP cycle.
//   - Next state is READ if en_i && !empty_i, else IDLE (back-to-back frames skip IDLE).
// - Frame length: 2 + 2*CLK_DIV*DATA_WIDTH + CLK_DIV cycles, from rd_en_o to frame_done_o inclusive.
// - Bits are transmitted as raw two's complement, with no offset or sign conversion.
// - Boundary cases:
//   - en_i falls mid-frame: the current frame completes; no further read is issued.
//   - empty_i rises mid-frame: no effect on the current frame.
//   - empty_i is sampled only in IDLE and at GAP exit.
//   - rst asserted mid-frame: outputs go to reset values immediately; the in-flight sample is dropped.
//   - The FIFO entry already popped is not restored.
//   - CLK_DIV=1: sclk_o toggles every cycle; the same state sequence applies.
// STRUCTURE
// - fifo_defines_pkg gains:
//   - rd_state_t: enum logic [2:0] {RD_IDLE, RD_READ, RD_LATCH, RD_SHIFT, RD_GAP}.
//   - RD_CLK_DIV_DEF = 2.
// - DATA_WIDTH is reused from the package.
// - One sub-module, sclk_div_cnt: divider counter with a half-period tick output, clear, and enable.
// - The FSM, shift register, and bit counter stay in the top module.
// TESTING (DATA_WIDTH=16, CLK_DIV=2, frame = 2+64+2 = 68 cycles)
// - Reset: hold rst with empty_i=0 and en_i=1.
//   -> all outputs at reset values; rd_en_o stays 0 throughout reset.
// - Single sample: FIFO holds 16'hA5C3, en_i=1.
//   -> rd_en_o at cycle 0; cs_n_o low from cycle 2.
//   -> sdo_o bit sequence 1010_0101_1100_0011, each bit stable across its sclk rising edge.
//   -> 16 sclk_o rising edges; cs_n_o high at cycle 66; frame_done_o at cycle 67.
// - Back-to-back: FIFO holds 16'h8000 then 16'h7FFF.
//   -> second rd_en_o at cycle 68 with no IDLE cycle in between.
//   -> DAC captures -32768 then +32767.
// - Empty FIFO: empty_i=1 for 200 cycles, en_i=1.
//   -> rd_en_o=0, cs_n_o=1, busy_o=0 throughout; on empty_i falling, rd_en_o within 1 cycle.
// - Mid-frame events: en_i=0 at cycle 20.
//   -> frame completes at cycle 67 and no further rd_en_o.
//   Repeat with rst pulsed at cycle 30.
//   -> cs_n_o=1 and sclk_o=0 in the reset cycle; the next frame starts cleanly after release.
// - Formal checks:
//   - rd_en_o is never asserted with empty_i=1.
//   - cs_n_o is low only in SHIFT.
//   - sdo_o never changes while sclk_o is high.

Source files
------------

// File: rtl/fifo_defines_pkg.sv
// fifo_defines_pkg
// Shared definitions for the sample FIFO path: funct_generator fills the
// FIFO and fifo_sample_reader drains it onto the DAC serial link.
//   DATA_WIDTH      sample width stored in the FIFO and shifted to the DAC
//   RD_CLK_DIV_DEF  default clk cycles per sclk half-period for the reader
//   rd_state_t      reader FSM state encoding
package fifo_defines_pkg;

    localparam int unsigned DATA_WIDTH     = 16;
    localparam int unsigned RD_CLK_DIV_DEF = 2;

    typedef enum logic [2:0] {
        RD_IDLE,
        RD_READ,
        RD_LATCH,
        RD_SHIFT,
        RD_GAP
    } rd_state_t;

endpackage

// File: rtl/fifo_sample_reader_if.sv
// fifo_sample_reader_if
// Bundles the FIFO read port and the DAC pin side of fifo_sample_reader.
//   en_i, empty_i, data_i      inputs to the reader (enable, FIFO flag/data)
//   rd_en_o                    FIFO read strobe
//   cs_n_o, sclk_o, sdo_o      DAC serial link
//   busy_o, frame_done_o       status
// Modport slave is taken by the reader; master by whatever drives it.
interface fifo_sample_reader_if;
    import fifo_defines_pkg::*;

    logic                  en_i;
    logic                  empty_i;
    logic [DATA_WIDTH-1:0] data_i;
    logic                  rd_en_o;
    logic                  cs_n_o;
    logic                  sclk_o;
    logic                  sdo_o;
    logic                  busy_o;
    logic                  frame_done_o;

    modport slave (
        input  en_i, empty_i, data_i,
        output rd_en_o, cs_n_o, sclk_o, sdo_o, busy_o, frame_done_o
    );

    modport master (
        output en_i, empty_i, data_i,
        input  rd_en_o, cs_n_o, sclk_o, sdo_o, busy_o, frame_done_o
    );

endinterface

// File: rtl/fifo_sample_reader_sclk_div_cnt.sv
// sclk_div_cnt
// Divider counter running 0..DIV-1 while enabled; tick_o marks the last
// cycle of each half-period (counter at DIV-1 and about to wrap).
//   clk, rst   clock and asynchronous active-high reset
//   clr_i      synchronous clear to 0 (has priority over en_i)
//   en_i       count enable
//   cnt_o      current count
//   tick_o     high on the final cycle of a half-period
module sclk_div_cnt #(
    parameter int unsigned DIV = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr_i,
    input  logic       en_i,
    output logic [7:0] cnt_o,
    output logic       tick_o
);

    localparam logic [7:0] LAST = 8'(DIV - 1);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = 8'd0;
        end else if (en_i) begin
            cnt_d = (cnt_q == LAST) ? 8'd0 : cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign tick_o = en_i && !clr_i && (cnt_q == LAST);

endmodule

// File: rtl/fifo_sample_reader.sv
// fifo_sample_reader
// Read side of the sample FIFO. When enabled and the FIFO is non-empty it
// pops one signed sample and shifts it MSB-first to an SPI-style DAC
// (sdo changes on sclk fall, DAC samples on rise), one sample per frame.
//   clk, rst   clock and asynchronous active-high reset
//   bus        fifo_sample_reader_if.slave: en_i, empty_i, data_i in;
//              rd_en_o, cs_n_o, sclk_o, sdo_o, busy_o, frame_done_o out
// Frame: READ(1) LATCH(1) SHIFT(2*CLK_DIV*DATA_WIDTH) GAP(CLK_DIV).
// Every output is a register; each _d is computed from the next state so
// the output lines up with the state it belongs to.
module fifo_sample_reader
    import fifo_defines_pkg::*;
#(
    parameter int unsigned CLK_DIV = RD_CLK_DIV_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    fifo_sample_reader_if.slave  bus
);

    localparam int unsigned BW = $clog2(DATA_WIDTH);
    // Count value one cycle before the final GAP cycle (unused when CLK_DIV=1).
    localparam logic [7:0] GAP_PRE_LAST = 8'(CLK_DIV - 2);

    rd_state_t             state_q, state_d;
    logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
    logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
    logic                  rd_en_q, rd_en_d;
    logic                  cs_n_q, cs_n_d;
    logic                  sclk_q, sclk_d;
    logic                  sdo_q, sdo_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic                  div_en;
    logic                  div_clr;
    logic [7:0]            div_cnt;
    logic                  div_tick;

    sclk_div_cnt #(
        .DIV (CLK_DIV)
    ) u_div (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (div_clr),
        .en_i   (div_en),
        .cnt_o  (div_cnt),
        .tick_o (div_tick)
    );

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        cs_n_d    = cs_n_q;
        sclk_d    = sclk_q;
        sdo_d     = sdo_q;
        done_d    = 1'b0;
        div_en    = 1'b0;
        div_clr   = 1'b1;

        case (state_q)
            RD_IDLE: begin
                if (bus.en_i && !bus.empty_i) begin
                    state_d = RD_READ;
                end
            end
            RD_READ: begin
                state_d = RD_LATCH;
            end
            RD_LATCH: begin
                // Registered FIFO: data_i is valid now, one cycle after rd_en_o.
                shreg_d   = bus.data_i;
                bit_cnt_d = BW'(DATA_WIDTH - 1);
                cs_n_d    = 1'b0;
                sclk_d    = 1'b0;
                sdo_d     = bus.data_i[DATA_WIDTH-1];
                state_d   = RD_SHIFT;
            end
            RD_SHIFT: begin
                div_en  = 1'b1;
                div_clr = 1'b0;
                if (div_tick) begin
                    if (!sclk_q) begin
                        sclk_d = 1'b1;
                    end else begin
                        // Falling edge: present the next bit while sclk is low.
                        sclk_d  = 1'b0;
                        shreg_d = {shreg_q[DATA_WIDTH-2:0], 1'b0};
                        sdo_d   = shreg_q[DATA_WIDTH-2];
                        if (bit_cnt_q == '0) begin
                            cs_n_d  = 1'b1;
                            state_d = RD_GAP;
                            // With a one-cycle gap the first GAP cycle is also the last.
                            done_d  = (CLK_DIV == 1);
                        end else begin
                            bit_cnt_d = bit_cnt_q - 1'b1;
                        end
                    end
                end
            end
            RD_GAP: begin
                // The divider wrapped to 0 on the last SHIFT tick, so it
                // times the gap without an explicit clear.
                div_en  = 1'b1;
                div_clr = 1'b0;
                if (div_tick) begin
                    state_d = (bus.en_i && !bus.empty_i) ? RD_READ : RD_IDLE;
                end else begin
                    done_d = (div_cnt == GAP_PRE_LAST);
                end
            end
            default: begin
                state_d = RD_IDLE;
            end
        endcase

        rd_en_d = (state_d == RD_READ);
        busy_d  = (state_d != RD_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= RD_IDLE;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            rd_en_q   <= 1'b0;
            cs_n_q    <= 1'b1;
            sclk_q    <= 1'b0;
            sdo_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            rd_en_q   <= rd_en_d;
            cs_n_q    <= cs_n_d;
            sclk_q    <= sclk_d;
            sdo_q     <= sdo_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus.rd_en_o      = rd_en_q;
    assign bus.cs_n_o       = cs_n_q;
    assign bus.sclk_o       = sclk_q;
    assign bus.sdo_o        = sdo_q;
    assign bus.busy_o       = busy_q;
    assign bus.frame_done_o = done_q;

endmodule

// File: tb/tb_fifo_sample_reader.sv
// tb_fifo_sample_reader
// Directed bench for fifo_sample_reader (DATA_WIDTH=16, CLK_DIV=2).
// A small registered FIFO model feeds the reader; a DAC model captures
// sdo on every sclk rising edge and closes a word when cs_n rises.
module tb_fifo_sample_reader;
    import fifo_defines_pkg::*;

    logic clk;
    logic rst;
    logic force_empty;

    fifo_sample_reader_if bus ();

    fifo_sample_reader #(
        .CLK_DIV (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // ---------------- FIFO model (registered read) ----------------
    logic [15:0] mem [0:15];
    int wr_ptr = 0;
    int rd_ptr = 0;

    assign bus.empty_i = force_empty || (rd_ptr == wr_ptr);

    always @(posedge clk) begin
        if (bus.rd_en_o && (rd_ptr != wr_ptr)) begin
            bus.data_i <= mem[rd_ptr % 16];
            rd_ptr     <= rd_ptr + 1;
        end
    end

    task automatic push(input logic [15:0] v);
        mem[wr_ptr % 16] = v;
        wr_ptr++;
    endtask

    // ---------------- DAC model and protocol monitors ----------------
    logic [15:0] acc;
    int          rises;
    logic        prev_sclk, prev_sdo, prev_cs;
    int          dac_q[$];
    int          rise_q[$];
    int          sdo_glitch   = 0;
    int          rd_empty_err = 0;
    int          sclk_cs_err  = 0;

    initial begin
        acc = '0; rises = 0; prev_sclk = 1'b0; prev_sdo = 1'b0; prev_cs = 1'b1;
    end

    always @(negedge clk) begin
        if (rst) begin
            acc   = '0;
            rises = 0;
        end else begin
            if (bus.sclk_o && !prev_sclk) begin
                acc = {acc[14:0], bus.sdo_o};
                rises++;
            end
            if (bus.sclk_o && prev_sclk && (bus.sdo_o != prev_sdo)) sdo_glitch++;
            if (bus.rd_en_o && bus.empty_i) rd_empty_err++;
            if (bus.sclk_o && bus.cs_n_o) sclk_cs_err++;
            if (bus.cs_n_o && !prev_cs) begin
                dac_q.push_back(int'(acc));
                rise_q.push_back(rises);
                acc   = '0;
                rises = 0;
            end
        end
        prev_sclk = bus.sclk_o;
        prev_sdo  = bus.sdo_o;
        prev_cs   = bus.cs_n_o;
    end

    task automatic pop_dac(output int w, output int r);
        w = (dac_q.size() > 0) ? dac_q.pop_front() : -1;
        r = (rise_q.size() > 0) ? rise_q.pop_front() : -1;
    endtask

    // Waits (bounded) for rd_en_o, then follows the frame with cycle 0 = rd_en_o.
    // Stops at frame_done_o, at stop_at, or after 120 cycles.
    task automatic watch_frame(input int en_off_at, input int stop_at,
                               output int waited, output int cs_lo,
                               output int cs_hi, output int done_at);
        waited = 0; cs_lo = -1; cs_hi = -1; done_at = -1;
        while (!bus.rd_en_o && waited < 300) begin
            @(negedge clk);
            waited++;
        end
        if (!bus.rd_en_o) begin
            waited = -1;
            return;
        end
        for (int i = 1; i <= 120; i++) begin
            @(negedge clk);
            if (i == en_off_at) bus.en_i = 1'b0;
            if (!bus.cs_n_o && cs_lo < 0) cs_lo = i;
            if (bus.cs_n_o && cs_lo >= 0 && cs_hi < 0) cs_hi = i;
            if (bus.frame_done_o) begin
                done_at = i;
                break;
            end
            if (i == stop_at) break;
        end
    endtask

    int waited, cs_lo, cs_hi, done_at, word, nr, bad;

    initial begin
        rst         = 1'b1;
        bus.en_i    = 1'b1;
        force_empty = 1'b0;
        bus.data_i  = '0;
        push(16'hA5C3);   // FIFO non-empty while reset is held

        // ---- reset ----
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.rd_en_o) bad++;
        end
        check("reset_rd_en_quiet", bad, 0);
        check("reset_outputs",
              int'({bus.rd_en_o, bus.cs_n_o, bus.sclk_o, bus.sdo_o, bus.busy_o, bus.frame_done_o}),
              int'(6'b010000));
        rst = 1'b0;

        // ---- single sample 0xA5C3 ----
        watch_frame(0, 0, waited, cs_lo, cs_hi, done_at);
        check("single_rd_latency", waited, 1);
        check("single_cs_low", cs_lo, 2);
        check("single_cs_high", cs_hi, 66);
        check("single_done", done_at, 67);
        pop_dac(word, nr);
        check("single_word", word, 32'h0000A5C3);
        check("single_sclk_rises", nr, 16);

        // ---- back-to-back 0x8000 then 0x7FFF ----
        repeat (3) @(negedge clk);
        check("idle_busy_low", int'(bus.busy_o), 0);
        push(16'h8000);
        push(16'h7FFF);
        watch_frame(0, 0, waited, cs_lo, cs_hi, done_at);
        check("b2b_first_done", done_at, 67);
        watch_frame(0, 0, waited, cs_lo, cs_hi, done_at);
        check("b2b_second_rd_gap", waited, 1);   // rd_en_o at cycle 68
        check("b2b_second_done", done_at, 67);
        pop_dac(word, nr);
        check("b2b_word_neg_full", word, 32'h00008000);   // -32768
        pop_dac(word, nr);
        check("b2b_word_pos_full", word, 32'h00007FFF);   // +32767
        @(negedge clk);
        check("b2b_idle_after", int'(bus.busy_o), 0);

        // ---- empty FIFO for 200 cycles ----
        force_empty = 1'b1;
        push(16'h1234);
        bad = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.rd_en_o || !bus.cs_n_o || bus.busy_o) bad++;
        end
        check("empty_quiet", bad, 0);
        force_empty = 1'b0;
        watch_frame(0, 0, waited, cs_lo, cs_hi, done_at);
        check("empty_fall_rd_latency", waited, 1);
        pop_dac(word, nr);
        check("empty_word", word, 32'h00001234);

        // ---- en_i dropped at cycle 20 ----
        repeat (2) @(negedge clk);
        push(16'h1111);
        push(16'h2222);
        watch_frame(20, 0, waited, cs_lo, cs_hi, done_at);
        check("en_off_done", done_at, 67);
        pop_dac(word, nr);
        check("en_off_word", word, 32'h00001111);
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.rd_en_o) bad++;
        end
        check("en_off_no_read", bad, 0);

        // ---- rst pulsed at cycle 30 of the 0x2222 frame ----
        bus.en_i = 1'b1;
        watch_frame(0, 30, waited, cs_lo, cs_hi, done_at);
        check("rst_frame_started", waited, 1);
        rst = 1'b1;
        #1;
        check("rst_mid_outputs",
              int'({bus.rd_en_o, bus.cs_n_o, bus.sclk_o, bus.busy_o, bus.frame_done_o}),
              int'(5'b01000));
        repeat (2) @(negedge clk);
        push(16'h3333);
        rst = 1'b0;
        watch_frame(0, 0, waited, cs_lo, cs_hi, done_at);
        check("rst_next_rd", waited, 1);
        check("rst_next_done", done_at, 67);
        pop_dac(word, nr);
        check("rst_next_word", word, 32'h00003333);
        check("rst_no_partial_word", dac_q.size(), 0);

        // ---- protocol invariants over the whole run ----
        check("sdo_stable_sclk_high", sdo_glitch, 0);
        check("rd_en_never_empty", rd_empty_err, 0);
        check("sclk_only_cs_low", sclk_cs_err, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
